store_commit_buffer: RTL

STORE_COMMIT_BUFFER -- requirements
Module: store_commit_buffer

---
 rtl/store_commit_buffer_if.sv | 58 +++++
 rtl/store_commit_buffer.sv | 91 +++++++++
 2 files changed

// File: rtl/store_commit_buffer_if.sv
// Store commit buffer bus: ROB retirement, memory drain port and load probe.
// The DUT side uses the slave modport; the driver/observer uses master.
interface store_commit_buffer_if #(
  parameter int DEPTH = 8,
  parameter int CW = $clog2(DEPTH) + 1
);
  logic          commit_MemWrite;
  logic [31:0]   commit_Addr;
  logic [31:0]   commit_value;
  logic          sb_full;
  logic          sb_empty;
  logic [CW-1:0] sb_count;
  logic          sb_overflow;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ack;
  logic          ld_lookup_valid;
  logic [31:0]   ld_lookup_addr;
  logic          ld_fwd_hit;
  logic [31:0]   ld_fwd_data;

  modport slave (
    input  commit_MemWrite,
    input  commit_Addr,
    input  commit_value,
    output sb_full,
    output sb_empty,
    output sb_count,
    output sb_overflow,
    output mem_req,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  ld_lookup_valid,
    input  ld_lookup_addr,
    output ld_fwd_hit,
    output ld_fwd_data
  );

  modport master (
    output commit_MemWrite,
    output commit_Addr,
    output commit_value,
    input  sb_full,
    input  sb_empty,
    input  sb_count,
    input  sb_overflow,
    input  mem_req,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output ld_lookup_valid,
    output ld_lookup_addr,
    input  ld_fwd_hit,
    input  ld_fwd_data
  );
endinterface

// File: rtl/store_commit_buffer.sv
// Post-commit store FIFO: drains retired stores to data memory in order
// and forwards word data from the youngest matching entry to loads.
module store_commit_buffer #(
  parameter int DEPTH = 8,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input logic clk,
  input logic rst,
  store_commit_buffer_if.slave sb
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] vld;
  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;
  logic             ovf;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             hit;
  logic [31:0]      fwd;
  logic [PW-1:0]    idx;

  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign push  = sb.commit_MemWrite && !full;
  assign pop   = !empty && sb.mem_ack;

  // Push and pop never hit the same slot: that needs count 0 or DEPTH,
  // where pop or push respectively is blocked.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      vld   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_q[tail] <= sb.commit_Addr;
        data_q[tail] <= sb.commit_value;
        vld[tail]    <= 1'b1;
        tail         <= tail + 1'b1;
      end
      if (pop) begin
        vld[head] <= 1'b0;
        head      <= head + 1'b1;
      end
      if (sb.commit_MemWrite && full)
        ovf <= 1'b1;
      unique case (1'b1)
        push && !pop: count <= count + 1'b1;
        pop && !push: count <= count - 1'b1;
        default:      count <= count;
      endcase
    end
  end

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (sb.ld_lookup_valid && vld[idx] &&
          addr_q[idx][31:2] == sb.ld_lookup_addr[31:2]) begin
        hit = 1'b1;
        fwd = data_q[idx];
      end
    end
  end

  assign sb.sb_full     = full;
  assign sb.sb_empty    = empty;
  assign sb.sb_count    = count;
  assign sb.sb_overflow = ovf;
  assign sb.mem_req     = !empty;
  assign sb.mem_addr    = empty ? '0 : addr_q[head];
  assign sb.mem_wdata   = empty ? '0 : data_q[head];
  assign sb.ld_fwd_hit  = hit;
  assign sb.ld_fwd_data = fwd;
endmodule
